// File: rtl/rom_arbiter.sv
// rom_arbiter: round-robin arbiter issuing burst reads to a synchronous ROM,
// routing each registered ROM word back to the requester that issued it.
module rom_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8,
   parameter int LEN_WIDTH  = 4
) (
   input  logic                          clock,
   input  logic                          reset_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*LEN_WIDTH-1:0]  req_len,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic [ADDR_WIDTH-1:0]         rom_addr,
   input  logic [DATA_WIDTH-1:0]         rom_data,
   output logic [NUM_REQ-1:0]            rsp_valid,
   output logic [DATA_WIDTH-1:0]         rsp_data,
   output logic                          rsp_last,
   output logic                          busy
);
   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);
   typedef enum logic {IDLE, BURST} state_t;
   state_t state, state_next;
   logic [IW-1:0] ptr, owner, gnt, idx, s1_owner;
   logic gnt_any, accept, issue, s1_valid, s1_last;
   logic [LEN_WIDTH-1:0] remaining;
   logic [ADDR_WIDTH-1:0] addr_arr [NUM_REQ];
   logic [LEN_WIDTH-1:0] len_arr [NUM_REQ];

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
      assign addr_arr[i] = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      assign len_arr[i]  = req_len[i*LEN_WIDTH +: LEN_WIDTH];
   end

   // scan downward so the candidate closest after ptr is the last one written
   always_comb begin
      gnt = '0;
      idx = '0;
      gnt_any = 1'b0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx = IW'((int'(ptr) + k) % NUM_REQ);
         if (req_valid[idx]) begin
            gnt = idx;
            gnt_any = 1'b1;
         end
      end
   end

   assign accept     = (state == IDLE) && gnt_any;
   assign issue      = accept || ((state == BURST) && (remaining != '0));
   assign req_ready  = accept ? ONE << gnt : '0;
   assign busy       = (state == BURST);
   assign rsp_data   = rom_data;
   assign state_next = accept ? BURST : ((state == BURST) && (remaining == '0)) ? IDLE : state;

   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) state <= IDLE;
      else          state <= state_next;

   // s1 tags the address in flight at the ROM; rsp_valid/rsp_last form the second stage
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ptr       <= IW'(NUM_REQ - 1);
         rom_addr  <= '0;
         remaining <= '0;
         owner     <= '0;
         s1_valid  <= 1'b0;
         s1_last   <= 1'b0;
         s1_owner  <= '0;
         rsp_valid <= '0;
         rsp_last  <= 1'b0;
      end else begin
         if (accept) begin
            rom_addr  <= addr_arr[gnt];
            remaining <= len_arr[gnt];
            owner     <= gnt;
            ptr       <= gnt;
         end else if (issue) begin
            rom_addr  <= rom_addr + ADDR_WIDTH'(1);
            remaining <= remaining - LEN_WIDTH'(1);
         end
         s1_valid  <= issue;
         s1_owner  <= accept ? gnt : owner;
         s1_last   <= accept ? (len_arr[gnt] == '0) : (remaining == LEN_WIDTH'(1));
         rsp_valid <= s1_valid ? ONE << s1_owner : '0;
         rsp_last  <= s1_valid & s1_last;
      end
   end
endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: directed bench for rom_arbiter with a registered ROM model
// and an in-order queue of expected responses.
module tb_rom_arbiter;
   logic        clock, reset_n;
   logic [3:0]  req_valid, req_ready, rsp_valid;
   logic [31:0] req_addr;
   logic [15:0] req_len;
   logic [7:0]  rom_addr, rom_data, rsp_data;
   logic        rsp_last, busy;
   int checks = 0, failures = 0;

   typedef struct packed {logic [3:0] v; logic [7:0] d; logic l;} rsp_t;
   rsp_t exp_q[$];

   rom_arbiter dut (
      .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_addr(req_addr),
      .req_len(req_len), .req_ready(req_ready), .rom_addr(rom_addr), .rom_data(rom_data),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last), .busy(busy)
   );

   function automatic logic [7:0] mem(input logic [7:0] a);
      return (a * 8'd7) ^ 8'h5A;
   endfunction

   initial clock = 1'b0;
   always #5 clock = ~clock;
   always @(posedge clock) rom_data <= mem(rom_addr);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic set_req(input int r, input logic [7:0] a, input logic [3:0] l);
      req_addr[r*8 +: 8] = a;
      req_len[r*4 +: 4]  = l;
   endtask

   task automatic exp_rsp(input int r, input logic [7:0] a, input logic l);
      rsp_t e;
      e.v = 4'b0001 << r;
      e.d = mem(a);
      e.l = l;
      exp_q.push_back(e);
   endtask

   task automatic do_reset;
      reset_n = 1'b0;
      tick;
      reset_n = 1'b1;
   endtask

   always @(negedge clock) begin
      if (reset_n && rsp_valid != 4'b0) begin
         if (exp_q.size() == 0) check("spurious_rsp", rsp_valid, 4'b0);
         else begin
            rsp_t e;
            e = exp_q.pop_front();
            check("mon_owner", rsp_valid, e.v);
            check("mon_data", rsp_data, e.d);
            check("mon_last", rsp_last, e.l);
         end
      end
   end

   initial begin
      reset_n = 1'b0; req_valid = '0; req_addr = '0; req_len = '0;
      repeat (2) tick;
      check("rst_rom_addr", rom_addr, 8'h00);
      check("rst_rsp_valid", rsp_valid, 4'b0);
      check("rst_rsp_last", rsp_last, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_ready", req_ready, 4'b0);
      reset_n = 1'b1;

      // single word from requester 2
      set_req(2, 8'h10, 4'd0);
      req_valid = 4'b0100;
      #1 check("t1_ready", req_ready, 4'b0100);
      exp_rsp(2, 8'h10, 1'b1);
      tick;
      req_valid = '0;
      #1;
      check("t1_addr", rom_addr, 8'h10);
      check("t1_busy", busy, 1'b1);
      check("t1_ready_burst", req_ready, 4'b0);
      tick;
      check("t1_idle", busy, 1'b0);
      check("t1_rsp_valid", rsp_valid, 4'b0100);
      check("t1_rsp_data", rsp_data, mem(8'h10));
      check("t1_rsp_last", rsp_last, 1'b1);
      tick;
      check("t1_rsp_gone", rsp_valid, 4'b0);

      // wrapping burst from requester 1
      set_req(1, 8'hFE, 4'd3);
      req_valid = 4'b0010;
      #1 check("t2_ready", req_ready, 4'b0010);
      for (int w = 0; w < 4; w++) exp_rsp(1, 8'(8'hFE + w), w == 3);
      tick;
      req_valid = '0;
      for (int c = 0; c < 6; c++) begin
         check("t2_addr", rom_addr, (c < 4) ? 8'(8'hFE + c) : 8'h01);
         check("t2_busy", busy, c < 4);
         check("t2_rsp_valid", rsp_valid, (c >= 1 && c <= 4) ? 4'b0010 : 4'b0);
         if (c >= 1 && c <= 4) check("t2_rsp_data", rsp_data, mem(8'(8'hFE + c - 1)));
         check("t2_rsp_last", rsp_last, c == 4);
         tick;
      end

      // fairness with every requester held
      do_reset;
      for (int r = 0; r < 4; r++) set_req(r, 8'(8'h40 + r), 4'd0);
      req_valid = 4'b1111;
      for (int g = 0; g < 5; g++) begin
         #1 check("t3_grant", req_ready, 4'b0001 << (g % 4));
         exp_rsp(g % 4, 8'(8'h40 + g % 4), 1'b1);
         tick;
         check("t3_busy", busy, 1'b1);
         tick;
      end
      req_valid = '0;
      repeat (3) tick;

      // reset in the middle of a burst
      do_reset;
      set_req(3, 8'h20, 4'd7);
      set_req(0, 8'h70, 4'd0);
      req_valid = 4'b1000;
      #1 check("t4_ready", req_ready, 4'b1000);
      exp_rsp(3, 8'h20, 1'b0);
      tick;
      req_valid = '0;
      tick;
      tick;
      check("t4_addr3", rom_addr, 8'h22);
      reset_n = 1'b0;
      #1;
      check("t4_rst_addr", rom_addr, 8'h00);
      check("t4_rst_rsp", rsp_valid, 4'b0);
      check("t4_rst_last", rsp_last, 1'b0);
      check("t4_rst_busy", busy, 1'b0);
      tick;
      tick;
      reset_n = 1'b1;
      req_valid = 4'b1001;
      #1 check("t4_first_after_rst", req_ready, 4'b0001);
      exp_rsp(0, 8'h70, 1'b1);
      tick;
      req_valid = '0;
      repeat (3) tick;

      // back-to-back bursts
      do_reset;
      set_req(0, 8'h30, 4'd1);
      set_req(1, 8'h50, 4'd0);
      req_valid = 4'b0011;
      #1 check("t5_ready0", req_ready, 4'b0001);
      exp_rsp(0, 8'h30, 1'b0);
      exp_rsp(0, 8'h31, 1'b1);
      exp_rsp(1, 8'h50, 1'b1);
      tick;
      req_valid = 4'b0010;
      #1 check("t5_ready_burst", req_ready, 4'b0);
      tick;
      check("t5_busy", busy, 1'b1);
      tick;
      check("t5_gap", busy, 1'b0);
      check("t5_ready1", req_ready, 4'b0010);
      tick;
      req_valid = '0;
      repeat (4) tick;

      // requester 1 withdraws before it could be granted
      set_req(2, 8'h60, 4'd3);
      req_valid = 4'b0100;
      #1 check("t6_ready", req_ready, 4'b0100);
      for (int w = 0; w < 4; w++) exp_rsp(2, 8'(8'h60 + w), w == 3);
      tick;
      req_valid = '0;
      tick;
      set_req(1, 8'h99, 4'd0);
      req_valid = 4'b0010;
      #1 check("t6_no_ready", req_ready, 4'b0);
      tick;
      req_valid = '0;
      repeat (6) tick;
      check("t6_idle", busy, 1'b0);
      check("exp_queue_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
